// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift_sched delay-line scheduler.
//   ID_W      : width of the requester tag carried with each word
//   DEF_DEPTH : default pipeline depth
//   DEF_W     : default (and maximum) data width carried by a stage
//   stage_t   : one pipeline stage record {valid, id, data}
package shift_sched_pkg;

    localparam int unsigned ID_W      = 1;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_W     = 32;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [DEF_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/shift_sched_pipe.sv
// D-stage enable-gated delay line of stage records.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : shift every stage by one and load din into stage 0
//   clr        : clear all stage valids (takes priority over en)
//   din        : record entering stage 0
//   last       : record in stage D-1
//   valid      : per-stage valid bits, bit i = stage i
module shift_sched_pipe
    import shift_sched_pkg::*;
#(
    parameter int unsigned D = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  stage_t       din,
    output stage_t       last,
    output logic [D-1:0] valid
);

    stage_t stg [D];

    // Stage registers: reset, flush (valids only) or shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(D); i++) begin
                stg[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(D); i++) begin
                stg[i].valid <= 1'b0;
            end
        end else if (en) begin
            stg[0] <= din;
            for (int i = 1; i < int'(D); i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign last = stg[D-1];

    // Flatten stage valids for occupancy accounting.
    always_comb begin
        valid = '0;
        for (int i = 0; i < int'(D); i++) begin
            valid[i] = stg[i].valid;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler feeding a D-stage delay line.
//   clk, rst_n           : clock, synchronous active-low reset
//   req0_* / req1_*      : valid/ready producers; ready marks acceptance
//   flush                : drop every in-flight word
//   out_valid/data/id    : last pipeline stage, with out_ready backpressure
//   occupancy, busy      : count of valid stages, and occupancy != 0
//   grant_cnt0/1         : wrapping per-requester accept counters
// The stage record carries DEF_W data bits, so W must not exceed DEF_W.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int unsigned D  = DEF_DEPTH,
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic [W-1:0]             req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [W-1:0]             req1_data,
    output logic                     req1_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic                     out_id,
    input  logic                     out_ready,
    output logic [$clog2(D+1)-1:0]   occupancy,
    output logic                     busy,
    output logic [CW-1:0]            grant_cnt0,
    output logic [CW-1:0]            grant_cnt1
);

    localparam int unsigned OW = $clog2(D + 1);

    logic         adv;
    logic         allow;
    logic         grant0;
    logic         grant1;
    logic         rr;
    stage_t       din;
    stage_t       last;
    logic [D-1:0] vld;
    logic [D-1:0] vld_nxt;
    logic [OW-1:0] occ_nxt;

    // Arbitration: one grant per advancing, non-flush cycle; rr breaks ties.
    always_comb begin
        adv    = !last.valid || out_ready;
        allow  = rst_n && adv && !flush;
        grant0 = allow && req0_valid && (!req1_valid || !rr);
        grant1 = allow && req1_valid && (!req0_valid || rr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Word entering stage 0; a bubble when nobody is granted.
    always_comb begin
        din       = '0;
        din.valid = grant0 || grant1;
        din.id    = ID_W'(grant1);
        if (grant1) begin
            din.data = DEF_W'(req1_data);
        end else if (grant0) begin
            din.data = DEF_W'(req0_data);
        end
    end

    shift_sched_pipe #(
        .D (D)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .clr   (flush),
        .din   (din),
        .last  (last),
        .valid (vld)
    );

    assign out_valid = last.valid;
    assign out_data  = W'(last.data);
    assign out_id    = last.id[0];

    // Predict post-edge stage valids so occupancy is registered yet exact.
    always_comb begin
        vld_nxt = vld;
        if (flush) begin
            vld_nxt = '0;
        end else if (adv) begin
            vld_nxt = D'({vld, din.valid});
        end
        occ_nxt = '0;
        for (int i = 0; i < int'(D); i++) begin
            occ_nxt = occ_nxt + OW'(vld_nxt[i]);
        end
    end

    // Round-robin pointer, grant counters and status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr         <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            occupancy  <= '0;
            busy       <= 1'b0;
        end else begin
            if (grant0) begin
                rr         <= 1'b1;
                grant_cnt0 <= grant_cnt0 + CW'(1);
            end else if (grant1) begin
                rr         <= 1'b0;
                grant_cnt1 <= grant_cnt1 + CW'(1);
            end
            occupancy <= occ_nxt;
            busy      <= |vld_nxt;
        end
    end

endmodule
